fifo_flagged: RTL
=================

Name: fifo_flagged

Overview:
- Parametrised synchronous FIFO. Next generation of the team's basic sync FIFO.
- Adds:
  - occupancy count
  - almost-full / almost-empty thresholds
  - selectable standard or first-word-fall-through (FWFT) read mode
  - sticky overflow/underflow error flags
  - synchronous flush
  - pass-through when full
- Sits between producer/consumer blocks in the memio path wherever rate decoupling plus level-based flow control is needed.

Parameters:
- ADDRWIDTH, 4, log2 of capacity; DEPTH = 2**ADDRWIDTH words.
- WIDTH, 8, data word width in bits.
- FWFT, 0: 0 = standard registered read; 1 = first-word-fall-through.
- AFULL_LEVEL, DEPTH-2, almost_full asserted when count >= AFULL_LEVEL. Legal range 1..DEPTH.
- AEMPTY_LEVEL, 1, almost_empty asserted when count <= AEMPTY_LEVEL. Legal range 0..DEPTH-1.

Ports:
- clock  in  1  single clock, all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- enqueue  in  1  write request.
- data_in  in  WIDTH  write data.
- dequeue  in  1  read request (FWFT: consume head).
- flush  in  1  synchronous empty; errors kept.
- clear_errors  in  1  clears overflow/underflow.
- data_out  out  WIDTH  read data (FWFT: head word).
- data_valid  out  1  standard: read data valid pulse; FWFT: head valid (= !empty).
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AFULL_LEVEL.
- almost_empty  out  1  count <= AEMPTY_LEVEL.
- count  out  ADDRWIDTH+1  words held, 0..DEPTH.
- overflow  out  1  sticky: write rejected.
- underflow  out  1  sticky: read rejected.

Behaviour:
- Interface fixed: one clock; reset is synchronous and active-low.
- Reset (reset_n low at an edge) takes priority over everything. Values after reset:
  - pointers and count = 0
  - empty = 1, full = 0
  - almost_empty = 1, almost_full = 0
  - data_out = 0, data_valid = 0
  - overflow = 0, underflow = 0
  - RAM is not cleared.
- Accept rules, evaluated on pre-edge state:
  - rd_ok = dequeue && !empty.
  - wr_ok = enqueue && (!full || rd_ok). Pass-through: a write while full is accepted if a read is accepted in the same cycle.
  - Empty plus both requests: write accepted, read rejected.
- Count update: count <= count + wr_ok - rd_ok. full, empty, almost_* are combinational from registered count, so they change the cycle after the operation.
- Pointers: ADDRWIDTH+1 bits each; the extra msb disambiguates full vs empty on wrap. Addresses wrap DEPTH-1 -> 0.
- Standard mode (FWFT=0):
  - On rd_ok, data_out is loaded at that edge with the head word and data_valid = 1 for exactly one cycle.
  - Otherwise data_out holds its value and data_valid = 0.
  - Read latency is 1 cycle from dequeue.
- FWFT mode (FWFT=1):
  - The head word is held in an output register; data_valid = !empty.
  - A write into an empty FIFO appears on data_out the next cycle, together with empty falling.
  - On rd_ok the next word, if any, is on data_out the following cycle. Back-to-back dequeues sustain 1 word/cycle.
  - Capacity is still exactly DEPTH, and count includes the word in the output register.
- overflow:
  - Set when enqueue && !wr_ok.
  - Cleared by clear_errors.
  - Set has priority if set and clear happen in the same cycle.
- underflow: same set/clear rules as overflow, set when dequeue && !rd_ok.
- flush:
  - Pointers and count go to 0 and data_valid goes to 0 at the edge.
  - data_out holds its value; error flags are unchanged.
  - flush overrides enqueue/dequeue in the same cycle: no accept and no error set.
- Reset mid-operation: the in-flight read or write is discarded, and all state returns to the reset values above.

Decomposition:
- Package fifo_pkg holds:
  - the function computing count width
  - parameter-legality checks (elaboration-time assertions on AFULL_LEVEL and AEMPTY_LEVEL ranges)
  - the mode constants FIFO_STD = 0, FIFO_FWFT = 1
- One sub-module, fifo_ram: simple dual-port, one write port and one registered read port, DEPTH x WIDTH, no reset. fifo_flagged instantiates it and owns pointers, count, flags and the FWFT prefetch logic.

Test Plan (ADDRWIDTH=2, WIDTH=8, AFULL_LEVEL=3, AEMPTY_LEVEL=1):
- Reset with reset_n=0 for 2 cycles -> count=0, empty=1, almost_empty=1, full=0, overflow=0, data_out=0.
- FWFT=0: write 0x11, 0x22, 0x33, 0x44 -> count goes 1,2,3,4; almost_full rises with count=3; full with count=4. Then write 0x55 -> rejected, overflow=1, count stays 4.
- FWFT=0, full: enqueue 0x55 and dequeue in the same cycle -> next cycle data_out=0x11, data_valid=1, count=4, overflow unchanged. Drain all -> 0x22, 0x33, 0x44, 0x55 in order.
- FWFT=1, empty: write 0xA5 -> next cycle empty=0, data_out=0xA5. Write 0x5A then two back-to-back dequeues -> 0xA5 then 0x5A consumed, empty=1. A third dequeue -> underflow=1.
- Wrap: 10 write/read pairs at depth 4, values 0..9 -> output order 0..9 and count never exceeds 1 in standard mode. Then clear_errors -> flags=0.
- Two words held, assert flush together with enqueue -> count=0, empty=1, no overflow. Next write 0x77 then read -> 0x77.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the flagged synchronous FIFO: read-mode constants,
// count/pointer width helper and parameter range checks.
package fifo_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  // Count and pointers need one bit more than the address so DEPTH is representable.
  function automatic int count_width(input int addrwidth);
    return addrwidth + 1;
  endfunction

  function automatic bit afull_level_ok(input int depth, input int level);
    return (level >= 1) && (level <= depth);
  endfunction

  function automatic bit aempty_level_ok(input int depth, input int level);
    return (level >= 0) && (level <= depth - 1);
  endfunction

  function automatic bit mode_ok(input int mode);
    return (mode == FIFO_STD) || (mode == FIFO_FWFT);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port, no reset.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int ADDRWIDTH = 4,
  parameter int WIDTH     = 8
) (
  input  logic                 clock,
  input  logic                 we,
  input  logic [ADDRWIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic                 re,
  input  logic [ADDRWIDTH-1:0] raddr,
  output logic [WIDTH-1:0]     rdata
);

  localparam int DEPTH = 2 ** ADDRWIDTH;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Write and read in the same cycle to the same address return the old word.
  always_ff @(posedge clock) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fifo_flagged.sv
// Synchronous FIFO with occupancy count, level flags, sticky error flags,
// flush, pass-through when full and optional first-word-fall-through output.
module fifo_flagged
  import fifo_pkg::*;
#(
  parameter int ADDRWIDTH    = 4,
  parameter int WIDTH        = 8,
  parameter int FWFT         = FIFO_STD,
  parameter int AFULL_LEVEL  = (2 ** ADDRWIDTH) - 2,
  parameter int AEMPTY_LEVEL = 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               enqueue,
  input  logic [WIDTH-1:0]   data_in,
  input  logic               dequeue,
  input  logic               flush,
  input  logic               clear_errors,
  output logic [WIDTH-1:0]   data_out,
  output logic               data_valid,
  output logic               full,
  output logic               empty,
  output logic               almost_full,
  output logic               almost_empty,
  output logic [ADDRWIDTH:0] count,
  output logic               overflow,
  output logic               underflow
);

  localparam int DEPTH = 2 ** ADDRWIDTH;
  localparam int CW    = count_width(ADDRWIDTH);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_LEVEL);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_LEVEL);

  if (!afull_level_ok(DEPTH, AFULL_LEVEL)) begin : g_bad_afull
    $error("fifo_flagged: AFULL_LEVEL must lie in 1..DEPTH");
  end
  if (!aempty_level_ok(DEPTH, AEMPTY_LEVEL)) begin : g_bad_aempty
    $error("fifo_flagged: AEMPTY_LEVEL must lie in 0..DEPTH-1");
  end
  if (!mode_ok(FWFT)) begin : g_bad_mode
    $error("fifo_flagged: FWFT must be FIFO_STD or FIFO_FWFT");
  end

  logic [CW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic                 overflow_q, overflow_d, underflow_q, underflow_d;
  logic                 dvalid_q, dvalid_d;
  logic                 zero_q, zero_d;     // data_out forced to 0 until the first load after reset
  logic                 byp_q, byp_d;       // FWFT head was written straight into the bypass register
  logic [WIDTH-1:0]     byp_data_q, byp_data_d;
  logic                 rd_ok, wr_ok, head_wr;
  logic                 ram_we, ram_re;
  logic [ADDRWIDTH-1:0] ram_waddr, ram_raddr;
  logic [WIDTH-1:0]     ram_rdata;

  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AFULL_C);
  assign almost_empty = (count_q <= AEMPTY_C);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  assign data_valid   = (FWFT == FIFO_FWFT) ? !empty : dvalid_q;
  assign data_out     = zero_q ? '0 : (byp_q ? byp_data_q : ram_rdata);

  fifo_ram #(.ADDRWIDTH(ADDRWIDTH), .WIDTH(WIDTH)) u_ram (
    .clock (clock),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (data_in),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // Accept decisions, pointer/count/flag next state and RAM read control.
  always_comb begin
    rd_ok    = dequeue && !empty && !flush;
    wr_ok    = enqueue && (!full || rd_ok) && !flush;
    wr_ptr_d = wr_ptr_q + CW'(wr_ok);
    rd_ptr_d = rd_ptr_q + CW'(rd_ok);
    count_d  = count_q + CW'(wr_ok) - CW'(rd_ok);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end

    overflow_d  = flush ? overflow_q
                        : ((enqueue && !wr_ok) || (overflow_q && !clear_errors));
    underflow_d = flush ? underflow_q
                        : ((dequeue && !rd_ok) || (underflow_q && !clear_errors));

    ram_we    = wr_ok;
    ram_waddr = wr_ptr_q[ADDRWIDTH-1:0];
    head_wr   = 1'b0;
    if (FWFT == FIFO_STD) begin
      ram_re    = rd_ok;
      ram_raddr = rd_ptr_q[ADDRWIDTH-1:0];
      dvalid_d  = rd_ok;
    end else begin
      // Prefetch the word that becomes head; a word written straight into
      // the head slot cannot come from the RAM yet, so it is bypassed.
      ram_raddr = rd_ptr_d[ADDRWIDTH-1:0];
      head_wr   = wr_ok && (ram_waddr == ram_raddr);
      ram_re    = rd_ok && (count_d != '0) && !head_wr;
      dvalid_d  = 1'b0;
    end

    byp_d      = head_wr || (byp_q && !ram_re);
    byp_data_d = head_wr ? data_in : byp_data_q;
    zero_d     = zero_q && !(ram_re || head_wr);
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      dvalid_q    <= 1'b0;
      zero_q      <= 1'b1;
      byp_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      dvalid_q    <= dvalid_d;
      zero_q      <= zero_d;
      byp_q       <= byp_d;
    end
  end

  // Bypass data word; only observed while byp_q is set, so it needs no reset.
  always_ff @(posedge clock) begin
    byp_data_q <= byp_data_d;
  end

endmodule
